// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Sequential MIPS instruction encoder, the inverse of a decode stage. It takes
// decoded field bundles over a valid/ready handshake and packs each one into a
// 32-bit instruction word. The word is checked against the supported
// instruction set, tagged with its program-counter byte address, and buffered
// in a small FIFO so a loader can write it straight into instruction memory.
//
// Parameters
//   DEPTH      FIFO entries (power of 2, >= 2)
//   BASE_ADDR  byte address tagged on the first word after reset
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid/ready  input handshake (in_ready = !full && !rst)
//   in_fmt          00=R, 01=I, 10=J, 11=illegal
//   in_op, in_funct opcode / function code
//   in_rs/rt/rd     register numbers
//   in_shamt        shift amount (R)
//   in_imm          immediate (I)
//   in_addr         jump target field (J)
//   out_valid/ready output handshake on the FIFO head
//   out_inst/pc/err head word, its byte address, unsupported flag
//                   (all forced to 0 while out_valid=0)
//   err_count       unsupported words accepted, saturating
//   level           FIFO occupancy
// -----------------------------------------------------------------------------
module inst_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_fmt,
    input  logic [5:0]               in_op,
    input  logic [5:0]               in_funct,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_shamt,
    input  logic [15:0]              in_imm,
    input  logic [25:0]              in_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic                     out_err,
    output logic [15:0]              err_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_BAD = 2'b11
    } fmt_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    // ------------------------------------------------------------------
    // Supported instruction set
    // ------------------------------------------------------------------
    function automatic logic r_funct_ok(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0C, 6'h0D,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic i_op_ok(input logic [5:0] op);
        case (op)
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
            6'h0E, 6'h23, 6'h2B: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic j_op_ok(input logic [5:0] op);
        return (op == 6'h02) || (op == 6'h03);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [31:0]     pc_q, pc_d;
    logic [15:0]     err_cnt_q, err_cnt_d;

    logic [31:0]     enc_inst;
    logic            enc_ok;
    logic            full;
    logic            push;
    logic            pop;

    // ------------------------------------------------------------------
    // Field packing and legality
    // ------------------------------------------------------------------
    always_comb begin
        enc_inst = 32'h0;
        enc_ok   = 1'b0;
        case (fmt_e'(in_fmt))
            FMT_R: begin
                // R-type opcode is always zero; in_op is ignored.
                enc_inst = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
                enc_ok   = r_funct_ok(in_funct);
            end
            FMT_I: begin
                enc_inst = {in_op, in_rs, in_rt, in_imm};
                enc_ok   = i_op_ok(in_op);
            end
            FMT_J: begin
                enc_inst = {in_op, in_addr};
                enc_ok   = j_op_ok(in_op);
            end
            default: begin
                enc_inst = 32'h0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes. in_ready looks only at registered occupancy and rst, so
    // a pop while full cannot open a slot in the same cycle.
    // ------------------------------------------------------------------
    assign full      = (cnt_q == FULL_CNT);
    assign in_ready  = !full && !rst;
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        err_cnt_d = err_cnt_q;

        // Pointers wrap naturally because DEPTH is a power of 2.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            pc_d     = pc_q + 32'd4;
            if (!enc_ok && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            pc_q      <= BASE_ADDR;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty,
    // and push is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{inst: enc_inst, pc: pc_q, err: !enc_ok};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_inst = 32'h0;
        out_pc   = 32'h0;
        out_err  = 1'b0;
        if (out_valid) begin
            out_inst = mem_q[rd_ptr_q].inst;
            out_pc   = mem_q[rd_ptr_q].pc;
            out_err  = mem_q[rd_ptr_q].err;
        end
    end

    assign err_count = err_cnt_q;
    assign level     = cnt_q;

endmodule
